// File: rtl/time_keeper_module.sv
// Timekeeper: divides clk_500Hz to a 1 s tick and keeps a settable power-on hh:mm:ss plus a working hh:mm:ss.
// Optional macro WORKING_REMINDER_EN adds a one-cycle remind pulse every REMIND_HOURS of working time.
module time_keeper_module #(
    parameter int TICKS_PER_SEC = 500,
    parameter int REMIND_HOURS  = 2
) (
    input  logic       clk_500Hz,
    input  logic       rst_n,
    input  logic       power_on,
    input  logic       working,
    input  logic       set_mode,
    input  logic [1:0] set_sel,
    input  logic       inc_btn,
    input  logic       clear_working,
    output logic [5:0] power_on_hour,
    output logic [5:0] power_on_min,
    output logic [5:0] power_on_sec,
    output logic [5:0] working_hour,
    output logic [5:0] working_min,
    output logic [5:0] working_sec,
    output logic       sec_tick,
    output logic [1:0] state,
    output logic       remind
);

    typedef enum logic [1:0] {
        ST_OFF = 2'b00,
        ST_RUN = 2'b01,
        ST_SET = 2'b10
    } state_t;

    localparam int            PW       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);

    state_t        r_state;
    logic [PW-1:0] r_pre;
    logic          r_sec_tick;
    logic          r_inc_d;
    logic          r_inc_pulse;
    logic [5:0]    r_pon_h;
    logic [5:0]    r_pon_m;
    logic [5:0]    r_pon_s;
    logic [5:0]    r_wk_h;
    logic [5:0]    r_wk_m;
    logic [5:0]    r_wk_s;

    logic          w_run_stay;
    logic          w_run_next;
    logic [PW-1:0] w_pre_nxt;
    logic          w_tick_apply;
    logic          w_wk_inc;
    logic          w_adjust;
    logic          w_pon_s_last;
    logic          w_pon_m_last;
    logic          w_pon_h_last;
    logic          w_wk_s_last;
    logic          w_wk_m_last;
    logic          w_wk_h_last;

    always_comb begin
        w_run_stay   = power_on && (r_state == ST_RUN) && !set_mode;
        w_run_next   = power_on && ((r_state == ST_OFF) ||
                       (((r_state == ST_RUN) || (r_state == ST_SET)) && !set_mode));
        // Prescaler only advances while RUN persists; any exit or entry restarts it at 0.
        w_pre_nxt    = '0;
        if (w_run_stay && (r_pre != PRE_LAST)) begin
            w_pre_nxt = r_pre + 1'b1;
        end
        w_tick_apply = (r_state == ST_RUN) && r_sec_tick;
        w_wk_inc     = w_tick_apply && working && !clear_working;
        w_adjust     = (r_state == ST_SET) && r_inc_pulse;
        w_pon_s_last = (r_pon_s == 6'd59);
        w_pon_m_last = (r_pon_m == 6'd59);
        w_pon_h_last = (r_pon_h == 6'd23);
        w_wk_s_last  = (r_wk_s == 6'd59);
        w_wk_m_last  = (r_wk_m == 6'd59);
        w_wk_h_last  = (r_wk_h == 6'd59);
    end

    always_ff @(posedge clk_500Hz) begin
        if (!rst_n) begin
            r_state    <= ST_OFF;
            r_pre      <= '0;
            r_sec_tick <= 1'b0;
        end else begin
            r_pre      <= w_pre_nxt;
            r_sec_tick <= w_run_next && (w_pre_nxt == PRE_LAST);
            if (!power_on) begin
                r_state <= ST_OFF;
            end else begin
                case (r_state)
                    ST_OFF:  r_state <= ST_RUN;
                    ST_RUN:  if (set_mode) r_state <= ST_SET;
                    ST_SET:  if (!set_mode) r_state <= ST_RUN;
                    default: r_state <= ST_OFF;
                endcase
            end
        end
    end

    // The edge register runs in every state so a button already held on entry to SET never fires.
    always_ff @(posedge clk_500Hz) begin
        if (!rst_n) begin
            r_inc_d     <= 1'b0;
            r_inc_pulse <= 1'b0;
        end else begin
            r_inc_d     <= inc_btn;
            r_inc_pulse <= inc_btn && !r_inc_d;
        end
    end

    always_ff @(posedge clk_500Hz) begin
        if (!rst_n || !power_on || (r_state == ST_OFF)) begin
            r_pon_h <= '0;
            r_pon_m <= '0;
            r_pon_s <= '0;
        end else if (w_tick_apply) begin
            if (w_pon_s_last) begin
                r_pon_s <= '0;
                if (w_pon_m_last) begin
                    r_pon_m <= '0;
                    r_pon_h <= w_pon_h_last ? 6'd0 : r_pon_h + 6'd1;
                end else begin
                    r_pon_m <= r_pon_m + 6'd1;
                end
            end else begin
                r_pon_s <= r_pon_s + 6'd1;
            end
        end else if (w_adjust) begin
            // Manual adjust wraps the selected field alone, with no carry.
            case (set_sel)
                2'd0:    r_pon_s <= w_pon_s_last ? 6'd0 : r_pon_s + 6'd1;
                2'd1:    r_pon_m <= w_pon_m_last ? 6'd0 : r_pon_m + 6'd1;
                2'd2:    r_pon_h <= w_pon_h_last ? 6'd0 : r_pon_h + 6'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_500Hz) begin
        if (!rst_n || !power_on || (r_state == ST_OFF) || clear_working) begin
            r_wk_h <= '0;
            r_wk_m <= '0;
            r_wk_s <= '0;
        end else if (w_wk_inc) begin
            if (w_wk_s_last) begin
                r_wk_s <= '0;
                if (w_wk_m_last) begin
                    r_wk_m <= '0;
                    r_wk_h <= w_wk_h_last ? 6'd0 : r_wk_h + 6'd1;
                end else begin
                    r_wk_m <= r_wk_m + 6'd1;
                end
            end else begin
                r_wk_s <= r_wk_s + 6'd1;
            end
        end
    end

`ifdef WORKING_REMINDER_EN
    logic r_remind;

    // Fires only when an increment rolls into a nonzero multiple of REMIND_HOURS at mm:ss = 00:00.
    always_ff @(posedge clk_500Hz) begin
        if (!rst_n || !power_on) begin
            r_remind <= 1'b0;
        end else begin
            r_remind <= w_wk_inc && w_wk_s_last && w_wk_m_last && !w_wk_h_last &&
                        (((int'(r_wk_h) + 1) % REMIND_HOURS) == 0);
        end
    end

    assign remind = r_remind;
`else
    assign remind = 1'b0;
`endif

    // REMIND_HOURS below 1 has no meaning; this empty block keeps the parameter referenced in every build.
    if (REMIND_HOURS < 1) begin : g_remind_hours_invalid
    end

    assign power_on_hour = r_pon_h;
    assign power_on_min  = r_pon_m;
    assign power_on_sec  = r_pon_s;
    assign working_hour  = r_wk_h;
    assign working_min   = r_wk_m;
    assign working_sec   = r_wk_s;
    assign sec_tick      = r_sec_tick;
    assign state         = r_state;

endmodule

// File: doc/time_keeper_module.md
Name: time_keeper_module

Overview:
- Timekeeping stage directly upstream of the seven-segment time display.
- Divides the 500 Hz scan clock down to a 1 s tick and maintains two hh:mm:ss counters:
  - power-on time (time of day, settable);
  - accumulated working time.
- Both counters are registered outputs that feed the display's power_on_* and working_* inputs.

Parameters:
TICKS_PER_SEC, 500, clock cycles per second tick; the bench overrides it to 4.
REMIND_HOURS, 2, working-hour threshold for the reminder pulse (used only with WORKING_REMINDER_EN).

Ports:
clk_500Hz  input  1  sole clock
rst_n  input  1  synchronous active-low reset
power_on  input  1  level; system powered
working  input  1  level; working timer accumulates while high
set_mode  input  1  level; enter power-on time adjust
set_sel  input  2  adjust field: 0 sec, 1 min, 2 hour, 3 none
inc_btn  input  1  level (debounced); rising edge increments selected field
clear_working  input  1  level; clears working counters
power_on_hour  output  6  0..23
power_on_min  output  6  0..59
power_on_sec  output  6  0..59
working_hour  output  6  0..59
working_min  output  6  0..59
working_sec  output  6  0..59
sec_tick  output  1  one-cycle pulse per elapsed second
state  output  2  00 OFF, 01 RUN, 10 SET
remind  output  1  one-cycle reminder pulse

Behaviour:
- Reset (rst_n=0 at a clk_500Hz edge):
  - state=OFF; all counters, prescaler, inc edge register, sec_tick and remind go to 0.
- FSM, evaluated every edge; power_on=0 has top priority:
  - any state -> OFF when power_on=0;
  - OFF -> RUN when power_on=1;
  - RUN -> SET when set_mode=1;
  - SET -> RUN when set_mode=0.
- OFF:
  - all six counters and the prescaler are held at 0;
  - sec_tick=0.
- Prescaler:
  - active in RUN only; counts 0..TICKS_PER_SEC-1;
  - sec_tick=1 for the cycle in which the prescaler holds TICKS_PER_SEC-1; the prescaler then wraps to 0;
  - the first tick comes TICKS_PER_SEC cycles after entering RUN;
  - leaving RUN (to SET or OFF) clears the prescaler to 0.
- Counter update, on the edge where sec_tick=1:
  - power-on: sec 59->0 with carry to min; min 59->0 with carry to hour; hour 23->0. 23:59:59 wraps to 00:00:00.
  - working: increments only if working=1; same sec/min carry chain; hour 59->0 wraps.
- SET:
  - prescaler held at 0; both counters frozen except by the adjustments below.
  - inc_btn rising edge is detected against a registered copy; the field updates on the edge after the rising edge is sampled.
  - the update increments only the field selected by set_sel, with its own wrap (sec/min 59->0, hour 23->0) and no carry into other fields; set_sel=3 ignores it.
  - the inc edge register updates in every state, so a button held across entry into SET does not fire.
- clear_working=1 in RUN or SET zeroes all working counters on that edge; it overrides a simultaneous tick increment.
- All outputs are registered; no combinational path from input to output.

Optional Feature:
- Macro: WORKING_REMINDER_EN.
- Defined: remind pulses high for exactly one cycle on the edge where the working counter transitions to REMIND_HOURS:00:00, and again every further REMIND_HOURS hours (working_hour an integer multiple of REMIND_HOURS, min=sec=0, reached by increment). It never fires from clear or reset.
- Not defined: remind is tied to 0, with no extra logic.

Test Plan:
- TICKS_PER_SEC=4; reset, then power_on=1 -> state RUN; sec_tick at cycles 4, 8, 12 after entry; power_on_sec=3 after 12 cycles; working stays 0 with working=0.
- Preload power-on to 23:59:58 via SET, return to RUN, run 2 ticks -> 23:59:59 then 00:00:00; working (working=1) reads 00:00:02.
- SET with set_sel=1, three inc_btn pulses at min=58 -> 59, 00, 01; hour unchanged; holding inc_btn high for 10 cycles counts once.
- working=1 for 3 ticks, then clear_working on the same edge as a tick -> working 00:00:00; power-on advanced by 3.
- power_on dropped mid-count at 05:12:33 -> next edge: state OFF, all outputs 0; rst_n=0 held mid-RUN -> all 0 on the following edge.
- WORKING_REMINDER_EN with REMIND_HOURS=1, working preloaded to 00:59:59 -> remind one cycle when 01:00:00 is reached; without the macro remind stays 0.
